// File: rtl/core_irq_pkg.sv
// Shared interrupt-sequencing definitions for the core: FSM encoding, handler
// vector and the SYSTEM/MRET instruction fields used to spot a handler return.
package core_irq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    JUMP    = 3'd2,
    SERVICE = 3'd3,
    RETURN  = 3'd4
  } irq_state_e;

  // Handler entry point; control_unit's target_PC mux uses the same constant.
  localparam logic [31:0] IRQ_VECTOR   = 32'h0000_00C0;

  localparam logic [6:0]  SYSCALL      = 7'b1110011;
  localparam logic [2:0]  MRET_FUNCT3  = 3'b000;
  localparam logic [11:0] MRET_FUNCT12 = 12'h302;

  function automatic logic is_mret(input logic [31:0] instr);
    return (instr[6:0] == SYSCALL) && (instr[14:12] == MRET_FUNCT3) &&
           (instr[31:20] == MRET_FUNCT12);
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: the lowest-numbered eligible line wins.
module irq_priority_encoder #(
  parameter int NUM_IRQ    = 4,
  parameter int CAUSE_BITS = 4
) (
  input  logic [NUM_IRQ-1:0]    eligible,
  output logic                  valid,
  output logic [CAUSE_BITS-1:0] index,
  output logic [NUM_IRQ-1:0]    onehot
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid     = 1'b1;
        index     = CAUSE_BITS'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// External interrupt entry/return sequencer: capture IRQ edges, wait for a safe
// decode slot, drain the pipeline, jump to the vector and later back to saved_PC.
module interrupt_sequencer
  import core_irq_pkg::*;
#(
  parameter int ADDRESS_BITS = 20,
  parameter int NUM_IRQ      = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CAUSE_BITS   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IRQ-1:0]      irq,
  input  logic [NUM_IRQ-1:0]      irq_mask,
  input  logic                    global_ie,
  input  logic [ADDRESS_BITS-1:0] pc_decode,
  input  logic                    decode_valid,
  input  logic                    mret_decode,
  input  logic                    JALR_branch_hazard,
  input  logic                    JAL_hazard,
  input  logic                    true_data_hazard,
  input  logic                    d_mem_issue_hazard,
  input  logic                    d_mem_recv_hazard,
  input  logic                    i_mem_hazard,
  output logic                    interrupt_stall,
  output logic                    interrupt_jump,
  output logic                    interrupt_execute,
  output logic                    interrupt_done,
  output logic [ADDRESS_BITS-1:0] saved_PC,
  output logic [CAUSE_BITS-1:0]   irq_cause,
  output logic                    in_handler
);

  localparam int CNT_BITS = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  irq_state_e state, state_next;

  logic [NUM_IRQ-1:0]    irq_prev;
  logic [NUM_IRQ-1:0]    pending;
  logic [NUM_IRQ-1:0]    eligible;
  logic [NUM_IRQ-1:0]    ack_line;
  logic [NUM_IRQ-1:0]    ack_mask;
  logic [NUM_IRQ-1:0]    sel_onehot;
  logic [CAUSE_BITS-1:0] sel_index;
  logic                  sel_valid;
  logic [CNT_BITS-1:0]   drain_count;
  logic                  take_ok;
  logic                  return_ok;

  assign eligible = pending & irq_mask;

  irq_priority_encoder #(
    .NUM_IRQ    (NUM_IRQ),
    .CAUSE_BITS (CAUSE_BITS)
  ) u_prio (
    .eligible (eligible),
    .valid    (sel_valid),
    .index    (sel_index),
    .onehot   (sel_onehot)
  );

  // Entry only at a decode slot that will not be squashed or replayed.
  assign take_ok = global_ie & sel_valid & decode_valid & ~JALR_branch_hazard &
                   ~JAL_hazard & ~d_mem_issue_hazard & ~d_mem_recv_hazard &
                   ~mret_decode;

  assign return_ok = mret_decode & decode_valid & ~true_data_hazard & ~i_mem_hazard;

  // The ack uses the line latched at entry, not the live selection.
  assign ack_mask = (state == JUMP) ? ack_line : '0;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending | (irq & ~irq_prev)) & ~ack_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      saved_PC    <= '0;
      irq_cause   <= '0;
      ack_line    <= '0;
      drain_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_ok) begin
            saved_PC    <= pc_decode;
            irq_cause   <= sel_index;
            ack_line    <= sel_onehot;
            drain_count <= CNT_BITS'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_count != '0) drain_count <= drain_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_ok) state_next = DRAIN;
      DRAIN:   if (drain_count == '0) state_next = JUMP;
      JUMP:    state_next = SERVICE;
      SERVICE: if (return_ok) state_next = RETURN;
      RETURN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign interrupt_stall   = (state == DRAIN);
  assign interrupt_jump    = (state == JUMP) || (state == RETURN);
  assign interrupt_execute = (state == JUMP);
  assign interrupt_done    = (state == RETURN);
  assign in_handler        = (state == SERVICE) || (state == RETURN);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry timing, priority, hazard gating,
// no-nesting, masking/enable and reset abort, all against hand-derived values.
module tb_interrupt_sequencer;

  localparam int AB = 20;
  localparam int NI = 4;
  localparam int CB = 4;

  // Output bundle order: {stall, jump, execute, done, in_handler}
  localparam logic [4:0] O_IDLE    = 5'b00000;
  localparam logic [4:0] O_DRAIN   = 5'b10000;
  localparam logic [4:0] O_JUMP    = 5'b01100;
  localparam logic [4:0] O_SERVICE = 5'b00001;
  localparam logic [4:0] O_RETURN  = 5'b01011;

  logic          clock = 1'b0;
  logic          reset;
  logic [NI-1:0] irq, irq_mask;
  logic          global_ie;
  logic [AB-1:0] pc_decode;
  logic          decode_valid, mret_decode;
  logic          JALR_branch_hazard, JAL_hazard, true_data_hazard;
  logic          d_mem_issue_hazard, d_mem_recv_hazard, i_mem_hazard;
  logic          interrupt_stall, interrupt_jump, interrupt_execute, interrupt_done;
  logic [AB-1:0] saved_PC;
  logic [CB-1:0] irq_cause;
  logic          in_handler;

  int n_checks = 0;
  int n_errors = 0;
  int jump_count = 0;
  int rule_violations = 0;

  interrupt_sequencer #(
    .ADDRESS_BITS (AB),
    .NUM_IRQ      (NI),
    .DRAIN_CYCLES (3),
    .CAUSE_BITS   (CB)
  ) u_dut (
    .clock              (clock),
    .reset              (reset),
    .irq                (irq),
    .irq_mask           (irq_mask),
    .global_ie          (global_ie),
    .pc_decode          (pc_decode),
    .decode_valid       (decode_valid),
    .mret_decode        (mret_decode),
    .JALR_branch_hazard (JALR_branch_hazard),
    .JAL_hazard         (JAL_hazard),
    .true_data_hazard   (true_data_hazard),
    .d_mem_issue_hazard (d_mem_issue_hazard),
    .d_mem_recv_hazard  (d_mem_recv_hazard),
    .i_mem_hazard       (i_mem_hazard),
    .interrupt_stall    (interrupt_stall),
    .interrupt_jump     (interrupt_jump),
    .interrupt_execute  (interrupt_execute),
    .interrupt_done     (interrupt_done),
    .saved_PC           (saved_PC),
    .irq_cause          (irq_cause),
    .in_handler         (in_handler)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (interrupt_jump) jump_count++;
    if ((interrupt_execute && interrupt_done) || (interrupt_stall && interrupt_jump))
      rule_violations++;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {interrupt_stall, interrupt_jump, interrupt_execute, interrupt_done, in_handler};
  endfunction

  // From the first DRAIN cycle: two more stall cycles, JUMP, then SERVICE.
  task automatic run_to_service(input string tag);
    tick(); check({tag, "_stall2"}, 32'(outs()), 32'(O_DRAIN));
    tick(); check({tag, "_stall3"}, 32'(outs()), 32'(O_DRAIN));
    tick(); check({tag, "_jump"},   32'(outs()), 32'(O_JUMP));
    tick(); check({tag, "_svc"},    32'(outs()), 32'(O_SERVICE));
  endtask

  task automatic finish_handler(input string tag, input logic [AB-1:0] exp_pc);
    mret_decode = 1'b1;
    tick();
    mret_decode = 1'b0;
    check({tag, "_ret"},    32'(outs()), 32'(O_RETURN));
    check({tag, "_ret_pc"}, 32'(saved_PC), 32'(exp_pc));
    tick(); check({tag, "_idle"}, 32'(outs()), 32'(O_IDLE));
  endtask

  initial begin
    int jumps_before;
    reset = 1'b1; irq = '0; irq_mask = 4'hF; global_ie = 1'b1;
    pc_decode = 20'h00100; decode_valid = 1'b1; mret_decode = 1'b0;
    JALR_branch_hazard = 1'b0; JAL_hazard = 1'b0; true_data_hazard = 1'b0;
    d_mem_issue_hazard = 1'b0; d_mem_recv_hazard = 1'b0; i_mem_hazard = 1'b0;
    tick(); tick();
    check("rst_outs",    32'(outs()), 32'(O_IDLE));
    check("rst_saved",   32'(saved_PC), 32'h0);
    check("rst_cause",   32'(irq_cause), 32'h0);
    check("rst_pending", 32'(u_dut.pending), 32'h0);
    reset = 1'b0;
    tick();

    // Single line entry with exact timing.
    irq = 4'b0100;
    tick(); check("t1_capture", 32'(u_dut.pending), 32'h4);
    check("t1_idle", 32'(outs()), 32'(O_IDLE));
    tick(); check("t1_drain", 32'(outs()), 32'(O_DRAIN));
    check("t1_saved", 32'(saved_PC), 32'h00100);
    check("t1_cause", 32'(irq_cause), 32'h2);
    run_to_service("t1");
    check("t1_ack", 32'(u_dut.pending), 32'h0);
    finish_handler("t1", 20'h00100);
    irq = '0; tick();

    // Simultaneous edges: lowest index first, then back-to-back re-take.
    irq = 4'b1010; pc_decode = 20'h00200;
    tick(); check("t2_capture", 32'(u_dut.pending), 32'hA);
    tick(); check("t2_drain", 32'(outs()), 32'(O_DRAIN));
    check("t2_cause1", 32'(irq_cause), 32'h1);
    run_to_service("t2a");
    check("t2_pend3", 32'(u_dut.pending), 32'h8);
    pc_decode = 20'h00300;
    finish_handler("t2a", 20'h00200);
    tick(); check("t2_retake", 32'(outs()), 32'(O_DRAIN));
    check("t2_cause3", 32'(irq_cause), 32'h3);
    check("t2_saved3", 32'(saved_PC), 32'h00300);
    run_to_service("t2b");
    finish_handler("t2b", 20'h00300);
    irq = '0; tick();

    // Branch hazard delays entry; saved_PC comes from the first clean slot.
    JALR_branch_hazard = 1'b1; irq = 4'b0001; pc_decode = 20'h00400;
    tick(); check("t3_hold1", 32'(outs()), 32'(O_IDLE));
    tick(); check("t3_hold2", 32'(outs()), 32'(O_IDLE));
    JALR_branch_hazard = 1'b0; pc_decode = 20'h00440;
    tick(); check("t3_drain", 32'(outs()), 32'(O_DRAIN));
    check("t3_saved", 32'(saved_PC), 32'h00440);
    check("t3_cause", 32'(irq_cause), 32'h0);
    run_to_service("t3");
    finish_handler("t3", 20'h00440);
    irq = '0; tick();

    // No nesting: an edge during SERVICE waits until after RETURN.
    irq = 4'b0100; pc_decode = 20'h00500;
    tick(); tick(); check("t4_drain", 32'(outs()), 32'(O_DRAIN));
    run_to_service("t4");
    irq = 4'b0101; pc_decode = 20'h00600;
    tick(); check("t4_nonest1", 32'(outs()), 32'(O_SERVICE));
    check("t4_pend0", 32'(u_dut.pending), 32'h1);
    tick(); check("t4_nonest2", 32'(outs()), 32'(O_SERVICE));
    finish_handler("t4", 20'h00500);
    tick(); check("t4_take0", 32'(outs()), 32'(O_DRAIN));
    check("t4_cause0", 32'(irq_cause), 32'h0);
    check("t4_saved", 32'(saved_PC), 32'h00600);
    run_to_service("t4b");
    finish_handler("t4b", 20'h00600);
    irq = '0; tick();

    // Masked line stays pending, taken once unmasked.
    irq_mask = 4'h0; irq = 4'b0010;
    tick(); tick(); tick();
    check("t5_masked", 32'(outs()), 32'(O_IDLE));
    check("t5_pend", 32'(u_dut.pending), 32'h2);
    irq_mask = 4'hF;
    tick(); check("t5_unmask", 32'(outs()), 32'(O_DRAIN));
    check("t5_cause", 32'(irq_cause), 32'h1);
    run_to_service("t5");
    finish_handler("t5", 20'h00600);
    irq = '0; tick();

    // Global enable low holds the sequence off.
    global_ie = 1'b0; irq = 4'b0010;
    tick(); tick(); tick();
    check("t6_gie_off", 32'(outs()), 32'(O_IDLE));
    check("t6_pend", 32'(u_dut.pending), 32'h2);
    global_ie = 1'b1;
    tick(); check("t6_gie_on", 32'(outs()), 32'(O_DRAIN));
    run_to_service("t6");
    finish_handler("t6", 20'h00600);
    irq = '0; tick();

    // Reset during the second drain cycle aborts with no jump.
    jumps_before = jump_count;
    irq = 4'b0100;
    tick(); tick(); check("t7_drain1", 32'(outs()), 32'(O_DRAIN));
    tick(); check("t7_drain2", 32'(outs()), 32'(O_DRAIN));
    reset = 1'b1; irq = '0;
    tick();
    check("t7_rst_outs", 32'(outs()), 32'(O_IDLE));
    check("t7_rst_state", 32'(u_dut.state), 32'h0);
    check("t7_rst_pend", 32'(u_dut.pending), 32'h0);
    check("t7_rst_saved", 32'(saved_PC), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t7_no_jump", 32'(jump_count - jumps_before), 32'h0);
    check("t7_idle", 32'(outs()), 32'(O_IDLE));

    check("exclusive_outputs", 32'(rule_violations), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
